// File: rtl/gpr_seq.sv
// -----------------------------------------------------------------------------
// gpr_seq -- fetch/execute sequencer for the R0..R7 register file (R7 = PC).
//
// Moore FSM that drives the register-file strobes, the write-data mux select,
// IR load and the memory handshake.
//
// Compile-time option:
//   GPR_SEQ_TIMEOUT_EN  when defined, every memory wait (fetch, LD, ST) is
//                       bounded by TIMEOUT cycles. On expiry the sequencer
//                       halts with BUSERR=1. When undefined, waits are
//                       unbounded and BUSERR is tied to 0.
//
// Parameters:
//   TIMEOUT   maximum MRDY wait cycles before a bus error (timeout build only)
//
// Ports:
//   CLK      in   clock, rising edge
//   RESET    in   synchronous active-high reset
//   IR[15:0] in   current instruction; opcode in IR[15:13]
//   MRDY     in   memory ready; completes MEM_RD/MEM_WR on the edge where high
//   WED      out  write register IR[9:7]
//   WE7      out  write R7 (PC)
//   REA      out  gate register IR[12:10] to QA
//   REA7     out  gate R7 to QA (memory address)
//   REB      out  gate register IR[6:4] to QB
//   RED2B    out  gate register IR[9:7] to QB (store data)
//   DSEL     out  D mux: 00 ALU, 01 mem data, 10 QA+2, 11 reset vector
//   PASSA    out  force ALU to pass QA
//   IR_LD    out  load IR from memory data on this edge
//   MEM_RD   out  memory read request
//   MEM_WR   out  memory write request
//   HALTED   out  sequencer stopped
//   ILL      out  stopped on an illegal opcode
//   BUSERR   out  stopped on an MRDY timeout
// -----------------------------------------------------------------------------
module gpr_seq #(
   parameter int TIMEOUT = 255
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [15:0] IR,
   input  logic        MRDY,
   output logic        WED,
   output logic        WE7,
   output logic        REA,
   output logic        REA7,
   output logic        REB,
   output logic        RED2B,
   output logic [1:0]  DSEL,
   output logic        PASSA,
   output logic        IR_LD,
   output logic        MEM_RD,
   output logic        MEM_WR,
   output logic        HALTED,
   output logic        ILL,
   output logic        BUSERR
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_VEC  = 3'd1;
   localparam logic [2:0] S_F1   = 3'd2;
   localparam logic [2:0] S_F2   = 3'd3;
   localparam logic [2:0] S_EX   = 3'd4;
   localparam logic [2:0] S_HALT = 3'd5;

   localparam logic [2:0] OP_ALU = 3'b000;
   localparam logic [2:0] OP_ST  = 3'b001;
   localparam logic [2:0] OP_LD  = 3'b010;
   localparam logic [2:0] OP_JMP = 3'b011;
   localparam logic [2:0] OP_HLT = 3'b111;

   localparam logic [1:0] D_ALU = 2'b00;
   localparam logic [1:0] D_MEM = 2'b01;
   localparam logic [1:0] D_PC2 = 2'b10;
   localparam logic [1:0] D_VEC = 2'b11;

   logic [2:0] state_q, state_d;
   logic       ill_q, ill_d;
   logic [2:0] op;
   logic       wait_st;   // state is waiting on MRDY
   logic       tmo;       // wait timed out on this edge

   // Register selects are applied by the register file, not here.
   logic [12:0] ir_unused;
   assign ir_unused = IR[12:0];

   assign op = IR[15:13];

   assign wait_st = (state_q == S_F1) ||
                    ((state_q == S_EX) && ((op == OP_ST) || (op == OP_LD)));

`ifdef GPR_SEQ_TIMEOUT_EN
   logic [7:0] cnt_q, cnt_d;
   logic       buserr_q;

   // Counter is zero whenever no wait is in progress, so it is already clear
   // on entry to F1, ST and LD. The timeout fires on the edge that would make
   // the count reach TIMEOUT; MRDY=1 on that edge suppresses it.
   assign cnt_d = (wait_st && !MRDY) ? cnt_q + 8'd1 : 8'd0;
   assign tmo   = wait_st && !MRDY && ({1'b0, cnt_q} + 9'd1 == 9'(TIMEOUT));

   always_ff @(posedge CLK) begin
      if (RESET) begin
         cnt_q    <= 8'd0;
         buserr_q <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         buserr_q <= buserr_q | tmo;
      end
   end

   assign BUSERR = buserr_q;
`else
   logic [7:0] timeout_unused;
   assign timeout_unused = TIMEOUT[7:0];
   assign tmo    = 1'b0;
   assign BUSERR = 1'b0;
`endif

   // Next-state logic
   always_comb begin
      state_d = state_q;
      ill_d   = ill_q;
      case (state_q)
         S_IDLE: state_d = S_VEC;
         S_VEC:  state_d = S_F1;
         S_F1: begin
            if (MRDY)     state_d = S_F2;
            else if (tmo) state_d = S_HALT;
         end
         S_F2:   state_d = S_EX;
         S_EX: begin
            case (op)
               OP_ALU, OP_JMP: state_d = S_F1;
               OP_ST, OP_LD: begin
                  if (MRDY)     state_d = S_F1;
                  else if (tmo) state_d = S_HALT;
               end
               OP_HLT: begin
                  state_d = S_HALT;
                  ill_d   = 1'b0;
               end
               default: begin
                  state_d = S_HALT;
                  ill_d   = 1'b1;
               end
            endcase
         end
         S_HALT: state_d = S_HALT;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= S_IDLE;
         ill_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ill_q   <= ill_d;
      end
   end

   // Output decode: state (plus IR opcode in EX), gated by MRDY only where a
   // write must coincide with completion of a memory read.
   always_comb begin
      WED    = 1'b0;
      WE7    = 1'b0;
      REA    = 1'b0;
      REA7   = 1'b0;
      REB    = 1'b0;
      RED2B  = 1'b0;
      DSEL   = D_ALU;
      PASSA  = 1'b0;
      IR_LD  = 1'b0;
      MEM_RD = 1'b0;
      MEM_WR = 1'b0;
      case (state_q)
         S_VEC: begin
            WE7  = 1'b1;
            DSEL = D_VEC;
         end
         S_F1: begin
            REA7   = 1'b1;
            MEM_RD = 1'b1;
            DSEL   = D_MEM;
            IR_LD  = MRDY;
         end
         S_F2: begin
            REA7 = 1'b1;
            DSEL = D_PC2;
            WE7  = 1'b1;
         end
         S_EX: begin
            case (op)
               OP_ALU: begin
                  REA  = 1'b1;
                  REB  = 1'b1;
                  DSEL = D_ALU;
                  WED  = 1'b1;
               end
               OP_ST: begin
                  REA    = 1'b1;
                  RED2B  = 1'b1;
                  MEM_WR = 1'b1;
               end
               OP_LD: begin
                  REA    = 1'b1;
                  MEM_RD = 1'b1;
                  DSEL   = D_MEM;
                  WED    = MRDY;
               end
               OP_JMP: begin
                  REA   = 1'b1;
                  PASSA = 1'b1;
                  DSEL  = D_ALU;
                  WE7   = 1'b1;
               end
               default: ;  // HLT and illegal opcodes: no side effects
            endcase
         end
         default: ;
      endcase
   end

   assign HALTED = (state_q == S_HALT);
   assign ILL    = ill_q;

endmodule

// File: tb/tb_gpr_seq.sv
// -----------------------------------------------------------------------------
// tb_gpr_seq -- directed self-checking bench for gpr_seq.
// Outputs are packed into one word and compared against hand-built constants.
// -----------------------------------------------------------------------------
module tb_gpr_seq;

   logic        CLK, RESET, MRDY;
   logic [15:0] IR;
   logic        WED, WE7, REA, REA7, REB, RED2B, PASSA, IR_LD;
   logic        MEM_RD, MEM_WR, HALTED, ILL, BUSERR;
   logic [1:0]  DSEL;

   int n_chk  = 0;
   int n_pass = 0;

   gpr_seq #(.TIMEOUT(4)) dut (
      .CLK(CLK), .RESET(RESET), .IR(IR), .MRDY(MRDY),
      .WED(WED), .WE7(WE7), .REA(REA), .REA7(REA7), .REB(REB),
      .RED2B(RED2B), .DSEL(DSEL), .PASSA(PASSA), .IR_LD(IR_LD),
      .MEM_RD(MEM_RD), .MEM_WR(MEM_WR), .HALTED(HALTED), .ILL(ILL),
      .BUSERR(BUSERR)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   logic [14:0] obs;
   assign obs = {WED, WE7, REA, REA7, REB, RED2B, DSEL, PASSA, IR_LD,
                 MEM_RD, MEM_WR, HALTED, ILL, BUSERR};

   // Single-bit positions in obs
   localparam logic [14:0] B_WED    = 15'h4000;
   localparam logic [14:0] B_WE7    = 15'h2000;
   localparam logic [14:0] B_REA    = 15'h1000;
   localparam logic [14:0] B_REA7   = 15'h0800;
   localparam logic [14:0] B_REB    = 15'h0400;
   localparam logic [14:0] B_RED2B  = 15'h0200;
   localparam logic [14:0] B_DMEM   = 15'h0080;  // DSEL=01
   localparam logic [14:0] B_DPC2   = 15'h0100;  // DSEL=10
   localparam logic [14:0] B_DVEC   = 15'h0180;  // DSEL=11
   localparam logic [14:0] B_PASSA  = 15'h0040;
   localparam logic [14:0] B_IRLD   = 15'h0020;
   localparam logic [14:0] B_MRD    = 15'h0010;
   localparam logic [14:0] B_MWR    = 15'h0008;
   localparam logic [14:0] B_HALT   = 15'h0004;
   localparam logic [14:0] B_ILL    = 15'h0002;
   localparam logic [14:0] B_BUS    = 15'h0001;

   // Expected output words per state
   localparam logic [14:0] O_IDLE = 15'h0000;
   localparam logic [14:0] O_VEC  = B_WE7 | B_DVEC;
   localparam logic [14:0] O_F1W  = B_REA7 | B_MRD | B_DMEM;
   localparam logic [14:0] O_F1R  = B_REA7 | B_MRD | B_DMEM | B_IRLD;
   localparam logic [14:0] O_F2   = B_REA7 | B_DPC2 | B_WE7;
   localparam logic [14:0] O_ALU  = B_REA | B_REB | B_WED;
   localparam logic [14:0] O_ST   = B_REA | B_RED2B | B_MWR;
   localparam logic [14:0] O_LDW  = B_REA | B_MRD | B_DMEM;
   localparam logic [14:0] O_LDR  = B_REA | B_MRD | B_DMEM | B_WED;
   localparam logic [14:0] O_JMP  = B_REA | B_PASSA | B_WE7;
   localparam logic [14:0] O_EX0  = 15'h0000;
   localparam logic [14:0] O_HLT  = B_HALT;
   localparam logic [14:0] O_ILLH = B_HALT | B_ILL;
   localparam logic [14:0] O_BUSH = B_HALT | B_BUS;

   // Drive inputs just after a falling edge, then let outputs settle.
   task automatic cyc(input logic rst, input logic mrdy, input logic [15:0] ir);
      @(negedge CLK);
      RESET = rst;
      MRDY  = mrdy;
      IR    = ir;
      #1;
   endtask

   task automatic test_reset();
      cyc(1, 0, 16'h0000);
      n_chk++; if (obs !== O_IDLE) $display("FAIL rst_c1: got %h want %h", obs, O_IDLE); else n_pass++;
      cyc(1, 0, 16'h0000);
      n_chk++; if (obs !== O_IDLE) $display("FAIL rst_c2: got %h want %h", obs, O_IDLE); else n_pass++;
      cyc(0, 0, 16'h0000);
      n_chk++; if (obs !== O_IDLE) $display("FAIL rst_rel: got %h want %h", obs, O_IDLE); else n_pass++;
      cyc(0, 0, 16'h0000);
      n_chk++; if (obs !== O_VEC) $display("FAIL vec: got %h want %h", obs, O_VEC); else n_pass++;
      cyc(0, 0, 16'h0000);
      n_chk++; if (obs !== O_F1W) $display("FAIL f1_wait1: got %h want %h", obs, O_F1W); else n_pass++;
      cyc(0, 0, 16'h0000);
      n_chk++; if (obs !== O_F1W) $display("FAIL f1_wait2: got %h want %h", obs, O_F1W); else n_pass++;
   endtask

   // Starts in F1; ALU op, then ALU op writing R7 (WED only, no WE7).
   task automatic test_alu();
      cyc(0, 1, 16'h0000);
      n_chk++; if (obs !== O_F1R) $display("FAIL alu_f1: got %h want %h", obs, O_F1R); else n_pass++;
      cyc(0, 1, 16'h0000);
      n_chk++; if (obs !== O_F2) $display("FAIL alu_f2: got %h want %h", obs, O_F2); else n_pass++;
      cyc(0, 1, 16'h0000);
      n_chk++; if (obs !== O_ALU) $display("FAIL alu_ex: got %h want %h", obs, O_ALU); else n_pass++;
      cyc(0, 1, 16'h0380);
      n_chk++; if (obs !== O_F1R) $display("FAIL alu_back_f1: got %h want %h", obs, O_F1R); else n_pass++;
      cyc(0, 1, 16'h0380);
      n_chk++; if (obs !== O_F2) $display("FAIL alu7_f2: got %h want %h", obs, O_F2); else n_pass++;
      cyc(0, 1, 16'h0380);
      n_chk++; if (obs !== O_ALU) $display("FAIL alu7_ex: got %h want %h", obs, O_ALU); else n_pass++;
   endtask

   // Starts in EX of the previous op (MRDY=1 moves it to F1).
   task automatic test_ld_wait();
      cyc(0, 1, 16'h4000);
      n_chk++; if (obs !== O_F1R) $display("FAIL ld_f1: got %h want %h", obs, O_F1R); else n_pass++;
      cyc(0, 1, 16'h4000);
      n_chk++; if (obs !== O_F2) $display("FAIL ld_f2: got %h want %h", obs, O_F2); else n_pass++;
      for (int i = 0; i < 3; i++) begin
         cyc(0, 0, 16'h4000);
         n_chk++; if (obs !== O_LDW) $display("FAIL ld_wait%0d: got %h want %h", i, obs, O_LDW); else n_pass++;
      end
      cyc(0, 1, 16'h4000);
      n_chk++; if (obs !== O_LDR) $display("FAIL ld_done: got %h want %h", obs, O_LDR); else n_pass++;
   endtask

   task automatic test_st();
      cyc(0, 1, 16'h2000);
      n_chk++; if (obs !== O_F1R) $display("FAIL st_f1: got %h want %h", obs, O_F1R); else n_pass++;
      cyc(0, 1, 16'h2000);
      n_chk++; if (obs !== O_F2) $display("FAIL st_f2: got %h want %h", obs, O_F2); else n_pass++;
      cyc(0, 1, 16'h2000);
      n_chk++; if (obs !== O_ST) $display("FAIL st_ex: got %h want %h", obs, O_ST); else n_pass++;
   endtask

   task automatic test_jmp_hlt();
      cyc(0, 1, 16'h6000);
      n_chk++; if (obs !== O_F1R) $display("FAIL jmp_f1: got %h want %h", obs, O_F1R); else n_pass++;
      cyc(0, 1, 16'h6000);
      cyc(0, 1, 16'h6000);
      n_chk++; if (obs !== O_JMP) $display("FAIL jmp_ex: got %h want %h", obs, O_JMP); else n_pass++;
      cyc(0, 1, 16'hE000);
      cyc(0, 1, 16'hE000);
      n_chk++; if (obs !== O_F2) $display("FAIL hlt_f2: got %h want %h", obs, O_F2); else n_pass++;
      cyc(0, 1, 16'hE000);
      n_chk++; if (obs !== O_EX0) $display("FAIL hlt_ex: got %h want %h", obs, O_EX0); else n_pass++;
      cyc(0, 0, 16'hE000);
      n_chk++; if (obs !== O_HLT) $display("FAIL hlt_state: got %h want %h", obs, O_HLT); else n_pass++;
      cyc(0, 1, 16'h0000);
      n_chk++; if (obs !== O_HLT) $display("FAIL hlt_sticky: got %h want %h", obs, O_HLT); else n_pass++;
   endtask

   task automatic test_illegal();
      cyc(1, 0, 16'h8000);
      cyc(0, 0, 16'h8000);
      n_chk++; if (obs !== O_IDLE) $display("FAIL ill_rst_idle: got %h want %h", obs, O_IDLE); else n_pass++;
      cyc(0, 1, 16'h8000);   // VEC
      cyc(0, 1, 16'h8000);   // F1
      cyc(0, 1, 16'h8000);   // F2
      cyc(0, 1, 16'h8000);
      n_chk++; if (obs !== O_EX0) $display("FAIL ill_ex: got %h want %h", obs, O_EX0); else n_pass++;
      cyc(0, 1, 16'h8000);
      n_chk++; if (obs !== O_ILLH) $display("FAIL ill_halt: got %h want %h", obs, O_ILLH); else n_pass++;
      cyc(0, 1, 16'h0000);
      n_chk++; if (obs !== O_ILLH) $display("FAIL ill_sticky: got %h want %h", obs, O_ILLH); else n_pass++;
   endtask

   task automatic test_reset_mid_ld();
      cyc(1, 0, 16'h4000);
      cyc(0, 0, 16'h4000);   // IDLE
      cyc(0, 1, 16'h4000);   // VEC
      cyc(0, 1, 16'h4000);   // F1
      cyc(0, 0, 16'h4000);   // F2
      cyc(0, 0, 16'h4000);
      n_chk++; if (obs !== O_LDW) $display("FAIL rld_wait: got %h want %h", obs, O_LDW); else n_pass++;
      cyc(1, 0, 16'h4000);
      n_chk++; if (obs !== O_LDW) $display("FAIL rld_pre: got %h want %h", obs, O_LDW); else n_pass++;
      cyc(0, 0, 16'h4000);
      n_chk++; if (obs !== O_IDLE) $display("FAIL rld_idle: got %h want %h", obs, O_IDLE); else n_pass++;
   endtask

`ifdef GPR_SEQ_TIMEOUT_EN
   task automatic test_timeout();
      cyc(1, 0, 16'h0000);
      cyc(0, 0, 16'h0000);   // IDLE
      cyc(0, 0, 16'h0000);   // VEC
      for (int i = 0; i < 4; i++) begin
         cyc(0, 0, 16'h0000);
         n_chk++; if (obs !== O_F1W) $display("FAIL tmo_wait%0d: got %h want %h", i, obs, O_F1W); else n_pass++;
      end
      cyc(0, 0, 16'h0000);
      n_chk++; if (obs !== O_BUSH) $display("FAIL tmo_halt: got %h want %h", obs, O_BUSH); else n_pass++;
   endtask
`endif

   initial begin
      RESET = 1'b1;
      MRDY  = 1'b0;
      IR    = 16'h0000;
      test_reset();
      test_alu();
      test_ld_wait();
      test_st();
      test_jmp_hlt();
      test_illegal();
      test_reset_mid_ld();
`ifdef GPR_SEQ_TIMEOUT_EN
      test_timeout();
`endif
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
